// File: rtl/wb_arbiter.sv
// Round-robin Wishbone interconnect: NUM_MASTERS masters share one bus that is
// address-decoded onto NUM_SLAVES slaves, with decode-error and ack-timeout responses.
module wb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_BYTES     = 1,
    parameter logic [NUM_SLAVES*ADDRESS_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDRESS_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*DATA_BYTES-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [ADDRESS_WIDTH-1:0]          s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic                              s_we_o,
    output logic [DATA_BYTES-1:0]             s_sel_o,
    output logic [2:0]                        s_cti_o,
    output logic [NUM_SLAVES-1:0]             s_cyc_o,
    output logic [NUM_SLAVES-1:0]             s_stb_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]             s_ack_i
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state, state_next;
    logic [NUM_MASTERS-1:0] grant, grant_next;
    logic [PTR_W-1:0]       pointer, pointer_next;
    logic [CNT_W-1:0]       count, count_next;
    logic                   err_reg, err_next;

    logic [PTR_W-1:0]         owner;
    logic                     owned, own_cyc, own_stb, own_we;
    logic [ADDRESS_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0]    own_dat;
    logic [DATA_BYTES-1:0]    own_sel;
    logic [2:0]               own_cti;
    logic                     hit, routed, ack_any, decode_err;
    logic [SLV_W-1:0]         slv;
    int                       nxt;

    // First requester at or after start, wrapping around.
    function automatic logic [NUM_MASTERS-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                                    input int start);
        logic [NUM_MASTERS-1:0] res;
        int idx;
        res = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = (start + i) % NUM_MASTERS;
            if (req[idx]) begin
                res      = '0;
                res[idx] = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        owner   = '0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_cti = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                owner   = PTR_W'(i);
                own_adr = m_adr_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                own_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                own_sel = m_sel_i[i*DATA_BYTES +: DATA_BYTES];
                own_cti = m_cti_i[i*3 +: 3];
            end
        end
    end

    assign owned   = |grant;
    assign own_cyc = |(m_cyc_i & grant);
    assign own_stb = |(m_stb_i & grant);
    assign own_we  = |(m_we_i & grant);

    // Reverse scan so the lowest-index matching slave wins.
    always_comb begin
        hit = 1'b0;
        slv = '0;
        for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
            if ((own_adr & SLAVE_MASK[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]) ==
                SLAVE_BASE[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]) begin
                hit = 1'b1;
                slv = SLV_W'(j);
            end
        end
    end

    assign routed = owned && hit;

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        m_dat_o = '0;
        if (routed) begin
            s_cyc_o[slv] = own_cyc;
            s_stb_o[slv] = own_stb;
            m_dat_o      = s_dat_i[slv*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign ack_any    = |(s_ack_i & s_stb_o);
    assign decode_err = owned && own_stb && !hit;

    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_we_o  = own_we;
    assign s_sel_o = own_sel;
    assign s_cti_o = own_cti;
    assign m_gnt_o = grant;
    assign m_ack_o = grant & {NUM_MASTERS{ack_any}};
    assign m_err_o = grant & {NUM_MASTERS{decode_err | err_reg}};

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        pointer_next = pointer;
        nxt          = 0;
        case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    grant_next = pick(m_cyc_i, int'(pointer));
                    state_next = OWNED;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    nxt          = (int'(owner) + 1) % NUM_MASTERS;
                    pointer_next = PTR_W'(nxt);
                    grant_next   = pick(m_cyc_i, nxt);
                    state_next   = (|m_cyc_i) ? OWNED : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ack beats the timeout threshold because any ack or error clears the count first.
    always_comb begin
        count_next = '0;
        err_next   = 1'b0;
        if (TIMEOUT_CYCLES != 0 && state == OWNED && own_stb && !ack_any &&
            !decode_err && !err_reg && grant_next == grant) begin
            if (count == CNT_W'(TIMEOUT_CYCLES - 1))
                err_next = 1'b1;
            else
                count_next = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            grant   <= '0;
            pointer <= '0;
            count   <= '0;
            err_reg <= 1'b0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            pointer <= pointer_next;
            count   <= count_next;
            err_reg <= err_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: two masters, slave0 at 0x1xxx, slave1 at 0x2xxx,
// four-cycle ack timeout.
module tb_wb_arbiter;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DB = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_wdat;
    logic [NM*DB-1:0]  m_sel;
    logic [NM*3-1:0]   m_cti;
    logic [DW-1:0]     m_rdat;
    logic [NM-1:0]     m_ack, m_err, m_gnt;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_wdat;
    logic              s_we;
    logic [DB-1:0]     s_sel;
    logic [2:0]        s_cti;
    logic [NS-1:0]     s_cyc, s_stb;
    logic [NS*DW-1:0]  s_rdat;
    logic [NS-1:0]     s_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [15:0] adr0;
        logic [15:0] adr1;
        logic [1:0]  ack;
        logic [1:0]  gnt;
        logic [1:0]  sstb;
        logic [1:0]  mack;
        logic [1:0]  merr;
        logic [7:0]  mdat;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_MASTERS   (NM),
        .NUM_SLAVES    (NS),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DATA_BYTES    (DB),
        .SLAVE_BASE    (32'h2000_1000),
        .SLAVE_MASK    (32'hF000_F000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_dat_i (m_wdat),
        .m_sel_i (m_sel),
        .m_cti_i (m_cti),
        .m_dat_o (m_rdat),
        .m_ack_o (m_ack),
        .m_err_o (m_err),
        .m_gnt_o (m_gnt),
        .s_adr_o (s_adr),
        .s_dat_o (s_wdat),
        .s_we_o  (s_we),
        .s_sel_o (s_sel),
        .s_cti_o (s_cti),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_dat_i (s_rdat),
        .s_ack_i (s_ack)
    );

    task automatic applyStimulus(input logic [1:0] cyc, input logic [1:0] stb,
                                 input logic [15:0] adr0, input logic [15:0] adr1,
                                 input logic [1:0] ack);
        m_cyc = cyc;
        m_stb = stb;
        m_adr = {adr1, adr0};
        s_ack = ack;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    initial begin
        // Vector fields: cyc, stb, adr0, adr1, ack | gnt, s_stb, m_ack, m_err, m_dat
        vecs[0]  = '{2'b00, 2'b00, 16'h1000, 16'h2000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
        vecs[1]  = '{2'b01, 2'b01, 16'h1000, 16'h2000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
        vecs[2]  = '{2'b01, 2'b01, 16'h1000, 16'h2000, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 8'hA5};
        vecs[3]  = '{2'b00, 2'b00, 16'h1000, 16'h2000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'hA5};
        vecs[4]  = '{2'b00, 2'b00, 16'h1000, 16'h2000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
        vecs[5]  = '{2'b11, 2'b11, 16'h1000, 16'h2000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
        vecs[6]  = '{2'b11, 2'b11, 16'h1000, 16'h2000, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 8'h3C};
        vecs[7]  = '{2'b01, 2'b01, 16'h1000, 16'h2000, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 8'h3C};
        vecs[8]  = '{2'b11, 2'b11, 16'h1000, 16'h2000, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 8'hA5};
        vecs[9]  = '{2'b10, 2'b10, 16'h1000, 16'h2000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'hA5};
        vecs[10] = '{2'b11, 2'b11, 16'h1000, 16'h2000, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 8'h3C};
        vecs[11] = '{2'b01, 2'b01, 16'h1000, 16'h2000, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 8'h3C};
        vecs[12] = '{2'b01, 2'b01, 16'h3000, 16'h2000, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 8'h00};
        vecs[13] = '{2'b00, 2'b00, 16'h3000, 16'h2000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00};
        vecs[14] = '{2'b00, 2'b00, 16'h1000, 16'h2000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};

        rst_n  = 1'b0;
        m_we   = 2'b00;
        m_wdat = {8'h22, 8'h11};
        m_sel  = 2'b11;
        m_cti  = '0;
        s_rdat = {8'h3C, 8'hA5};
        applyStimulus(2'b00, 2'b00, 16'h1000, 16'h2000, 2'b00);
        repeat (2) @(negedge clk);
        checkOutput("reset gnt", 32'(m_gnt), 32'h0);
        checkOutput("reset s_stb", 32'(s_stb), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].cyc, vecs[i].stb, vecs[i].adr0, vecs[i].adr1, vecs[i].ack);
            #1;
            checkOutput($sformatf("v%0d gnt", i),   32'(m_gnt),  32'(vecs[i].gnt));
            checkOutput($sformatf("v%0d s_stb", i), 32'(s_stb),  32'(vecs[i].sstb));
            checkOutput($sformatf("v%0d m_ack", i), 32'(m_ack),  32'(vecs[i].mack));
            checkOutput($sformatf("v%0d m_err", i), 32'(m_err),  32'(vecs[i].merr));
            checkOutput($sformatf("v%0d m_dat", i), 32'(m_rdat), 32'(vecs[i].mdat));
        end

        // Master1 write burst holds the grant while master0 waits.
        @(negedge clk);
        m_cti = {3'b010, 3'b000};
        m_we  = 2'b10;
        applyStimulus(2'b11, 2'b11, 16'h1000, 16'h2000, 2'b00);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            s_ack = 2'b10;
            if (b == 3) m_cti = {3'b111, 3'b000};
            #1;
            checkOutput($sformatf("burst%0d gnt", b), 32'(m_gnt), 32'h2);
            checkOutput($sformatf("burst%0d m_ack", b), 32'(m_ack), 32'h2);
            checkOutput($sformatf("burst%0d s_cti", b), 32'(s_cti), (b == 3) ? 32'h7 : 32'h2);
            checkOutput($sformatf("burst%0d s_we", b), 32'(s_we), 32'h1);
            checkOutput($sformatf("burst%0d s_dat", b), 32'(s_wdat), 32'h22);
            checkOutput($sformatf("burst%0d s_adr", b), 32'(s_adr), 32'h2000);
        end
        @(negedge clk);
        m_cti = '0;
        applyStimulus(2'b01, 2'b01, 16'h1000, 16'h2000, 2'b00);
        #1;
        checkOutput("burst drop gnt", 32'(m_gnt), 32'h2);
        checkOutput("burst drop m_ack", 32'(m_ack), 32'h0);
        @(negedge clk);
        s_ack = 2'b01;
        #1;
        checkOutput("handover gnt", 32'(m_gnt), 32'h1);
        checkOutput("handover m_ack", 32'(m_ack), 32'h1);
        checkOutput("handover m_dat", 32'(m_rdat), 32'hA5);
        checkOutput("handover s_we", 32'(s_we), 32'h0);
        @(negedge clk);
        applyStimulus(2'b00, 2'b00, 16'h1000, 16'h2000, 2'b00);
        @(negedge clk);
        #1;
        checkOutput("post burst idle gnt", 32'(m_gnt), 32'h0);

        // Unanswered strobe: error pulses on cycles 4 and 9; an ack on the threshold cycle suppresses it.
        applyStimulus(2'b01, 2'b01, 16'h1000, 16'h2000, 2'b00);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            s_ack = (c == 13) ? 2'b01 : 2'b00;
            #1;
            checkOutput($sformatf("timeout c%0d m_err", c), 32'(m_err),
                        (c == 4 || c == 9) ? 32'h1 : 32'h0);
            if (c == 0) checkOutput("timeout gnt", 32'(m_gnt), 32'h1);
        end
        @(negedge clk);
        applyStimulus(2'b00, 2'b00, 16'h1000, 16'h2000, 2'b00);

        // Asynchronous reset in the middle of a master1 burst.
        @(negedge clk);
        m_cti = {3'b010, 3'b000};
        applyStimulus(2'b11, 2'b11, 16'h1000, 16'h2000, 2'b00);
        @(negedge clk);
        #1;
        checkOutput("pre-reset gnt", 32'(m_gnt), 32'h2);
        @(negedge clk);
        s_ack = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset gnt", 32'(m_gnt), 32'h0);
        checkOutput("async reset s_stb", 32'(s_stb), 32'h0);
        checkOutput("async reset s_cyc", 32'(s_cyc), 32'h0);
        checkOutput("async reset m_ack", 32'(m_ack), 32'h0);
        checkOutput("async reset m_dat", 32'(m_rdat), 32'h0);
        checkOutput("async reset s_adr", 32'(s_adr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        s_ack = 2'b00;
        @(negedge clk);
        #1;
        checkOutput("post-reset tie gnt", 32'(m_gnt), 32'h1);
        checkOutput("post-reset tie s_stb", 32'(s_stb), 32'h1);
        applyStimulus(2'b00, 2'b00, 16'h1000, 16'h2000, 2'b00);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised Wishbone interconnect that replaces the hand-wired single-master mux in the top level: it arbitrates NUM_MASTERS bus masters (test pattern, VU meter, USB/serial bridge, …) round-robin onto one shared bus, decodes the address to one of NUM_SLAVES slaves (LED matrix, frame memory, …) and routes data and ack back to the granted master. It adds per-slave chip select, decode-error and ack-timeout error responses. It sits between the masters and slaves inside `top`, on the system clock domain.

## Interface
Parameters:
- NUM_MASTERS, 2, number of masters (1..8)
- NUM_SLAVES, 2, number of slaves (1..8)
- ADDRESS_WIDTH, 16, address bits
- DATA_WIDTH, 8, data bits
- DATA_BYTES, 1, select-line width
- SLAVE_BASE, {NUM_SLAVES*ADDRESS_WIDTH{0}}, packed base addresses; slave j in slice j
- SLAVE_MASK, {NUM_SLAVES*ADDRESS_WIDTH{0}}, packed decode masks; slave j matches when (adr & MASK_j) == BASE_j
- TIMEOUT_CYCLES, 255, cycles of unanswered strobe before error; 0 disables timeout

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDRESS_WIDTH  packed addresses
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_sel_i  in  NUM_MASTERS*DATA_BYTES  packed selects
- m_cti_i  in  NUM_MASTERS*3  packed cycle-type identifiers
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  ack, only to granted master
- m_err_o  out  NUM_MASTERS  error, only to granted master
- m_gnt_o  out  NUM_MASTERS  one-hot grant
- s_adr_o, s_dat_o, s_we_o, s_sel_o, s_cti_o  out  ADDRESS_WIDTH / DATA_WIDTH / 1 / DATA_BYTES / 3  shared slave bus
- s_cyc_o, s_stb_o  out  NUM_SLAVES  per-slave cycle/strobe (decoded)
- s_dat_i  in  NUM_SLAVES*DATA_WIDTH  packed read data
- s_ack_i  in  NUM_SLAVES  per-slave ack

## Operation
- States: IDLE (no grant), OWNED (one master granted). Registers: one-hot grant, round-robin pointer (log2 width), timeout counter, err register.
- IDLE: on clock edge with any m_cyc_i high, grant the first requester at or after pointer (wrapping), go OWNED.
- OWNED: grant held while owner's m_cyc_i high, across any number of strobes and bursts (cti ignored for arbitration). On edge where owner's m_cyc_i is low: pointer = owner+1 mod NUM_MASTERS; if another requester exists, grant it directly (stay OWNED), else IDLE. No pre-emption.
- Shared slave bus = granted master's signals (combinational mux); all zero when IDLE.
- Decode: lowest-index matching slave j gets s_cyc_o[j]=owner cyc, s_stb_o[j]=owner stb; all others 0.
- Return: m_dat_o = s_dat_i of decoded slave, 0 if none; m_ack_o[owner] = s_ack_i[decoded].
- Decode error: owner stb high and no slave matches → m_err_o[owner] high combinationally same cycle (acts as a default slave; no slave strobed).
- Timeout: counter increments each cycle owner stb high without ack/err; on reaching TIMEOUT_CYCLES, err register pulses m_err_o[owner] for exactly one cycle, counter clears. Counter clears on ack, err, stb low, or grant change. Counter width $clog2(TIMEOUT_CYCLES+1).

## Timing
- Reset (async, rst_n_i low): IDLE, grant 0, pointer 0, counter 0, err register 0; all outputs 0 immediately, including mid-transaction.
- Grant latency: m_cyc_i rises before edge n → m_gnt_o and slave strobes valid after edge n (1 cycle).
- Handover: owner drops cyc before edge k → next master granted after edge k; zero dead cycles.
- Ack, data, decode-error paths are combinational (0 cycles); timeout error is registered.
- Simultaneous ack and timeout threshold: ack wins, no error.
- Slave ack while no strobe routed to it: ignored.

## Test plan
- Reset then master0 cyc/stb to addr 0x1000 (slave0 base 0x1000, mask 0xF000) → gnt=01 one cycle later, s_stb_o=01, slave ack returns 0xA5 on m_dat_o with m_ack_o=01.
- Masters 0 and 1 request together continuously, each drops cyc after one transfer → grants alternate 01,10,01,10 with no idle cycle.
- Master1 4-beat burst (cti=010) while master0 requests → master1 keeps grant all 4 beats; master0 granted the cycle after master1 drops cyc.
- Address 0x3000 matching no slave → m_err_o[owner] high same cycle, no s_stb_o bit set.
- TIMEOUT_CYCLES=4, slave never acks → m_err_o one-cycle pulse 4 cycles after strobe; counter restarts.
- Assert rst_n_i mid-burst → all grants, strobes, acks 0 asynchronously; after release, pointer=0 and master0 wins a tie.
